// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, instruction field positions and opcode classification
// for the decode/issue stage.
`default_nettype none

package decode_pkg;

  localparam int XLEN  = 16;
  localparam int NREGS = 16;
  localparam int REG_W = 4;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_BEQ   = 4'hB;
  localparam logic [3:0] OP_RSV_C = 4'hC;
  localparam logic [3:0] OP_RSV_D = 4'hD;
  localparam logic [3:0] OP_RSV_E = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef struct packed {
    logic reads_rs1;
    logic reads_rs2;
    logic writes_rd;
    logic illegal;
  } op_class_t;

  // Reserved opcodes behave as NOP (no reads, no write) but are flagged illegal.
  function automatic op_class_t classify(input logic [3:0] opcode);
    op_class_t c;
    c = '0;
    case (opcode)
      OP_NOP, OP_HALT: begin
        c = '0;
      end
      OP_ADDI, OP_LOAD: begin
        c.reads_rs1 = 1'b1;
        c.writes_rd = 1'b1;
      end
      OP_STORE, OP_BEQ: begin
        c.reads_rs1 = 1'b1;
        c.reads_rs2 = 1'b1;
      end
      OP_RSV_C, OP_RSV_D, OP_RSV_E: begin
        c.illegal = 1'b1;
      end
      default: begin
        c.reads_rs1 = 1'b1;
        c.reads_rs2 = 1'b1;
        c.writes_rd = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard: pending-write vector with set/clear/kill updates and
// hazard queries that see a same-cycle writeback as already complete.
`default_nettype none

module decode_issue_scoreboard
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_idx,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_idx,
  input  logic             i_kill_en,
  input  logic [REG_W-1:0] i_kill_idx,
  input  logic [REG_W-1:0] i_q_rs1,
  input  logic [REG_W-1:0] i_q_rs2,
  input  logic [REG_W-1:0] i_q_rd,
  output logic             o_pend_rs1,
  output logic             o_pend_rs2,
  output logic             o_pend_rd,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  function automatic logic pending(input logic [REG_W-1:0] idx);
    return r_busy[idx] && !(i_clr_en && (i_clr_idx == idx));
  endfunction

  assign o_pend_rs1 = pending(i_q_rs1);
  assign o_pend_rs2 = pending(i_q_rs2);
  assign o_pend_rd  = pending(i_q_rd);
  assign o_busy     = r_busy;

  // Clears first so that a set to the same index in the same cycle wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en)  w_busy_nxt[i_clr_idx]  = 1'b0;
    if (i_kill_en) w_busy_nxt[i_kill_idx] = 1'b0;
    if (i_set_en)  w_busy_nxt[i_set_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
// decode_issue: decodes one instruction per cycle, stalls on scoreboard hazards
// and holds the issued instruction in a single ID/EX output register.
`default_nettype none

module decode_issue
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic [REG_W-1:0] RegRead1,
  output logic [REG_W-1:0] RegRead2,
  input  logic [XLEN-1:0]  ReadData1,
  input  logic [XLEN-1:0]  ReadData2,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_opcode,
  output logic [REG_W-1:0] out_rd,
  output logic [XLEN-1:0]  out_op_a,
  output logic [XLEN-1:0]  out_op_b,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_writes_rd,
  output logic             out_illegal,
  output logic [NREGS-1:0] busy
);

  logic [3:0]       w_opcode;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic [XLEN-1:0]  w_imm;
  op_class_t        w_cls;
  logic             w_pend_rs1;
  logic             w_pend_rs2;
  logic             w_pend_rd;
  logic             w_hazard;
  logic             w_space;
  logic             w_issue;
  logic             w_kill;

  logic             r_out_valid;
  logic [3:0]       r_out_opcode;
  logic [REG_W-1:0] r_out_rd;
  logic [XLEN-1:0]  r_out_op_a;
  logic [XLEN-1:0]  r_out_op_b;
  logic [XLEN-1:0]  r_out_imm;
  logic [XLEN-1:0]  r_out_pc;
  logic             r_out_writes_rd;
  logic             r_out_illegal;

  assign w_opcode = in_instr[OPC_LSB +: 4];
  assign w_rd     = in_instr[RD_LSB  +: REG_W];
  assign w_rs1    = in_instr[RS1_LSB +: REG_W];
  assign w_rs2    = in_instr[RS2_LSB +: REG_W];
  assign w_imm    = {{(XLEN-REG_W){w_rs2[REG_W-1]}}, w_rs2};
  assign w_cls    = classify(w_opcode);

  assign RegRead1 = w_rs1;
  assign RegRead2 = w_rs2;

  assign w_hazard = (w_cls.reads_rs1 && w_pend_rs1) ||
                    (w_cls.reads_rs2 && w_pend_rs2) ||
                    (w_cls.writes_rd && w_pend_rd);
  assign w_space  = !r_out_valid || out_ready;
  assign in_ready = w_space && !w_hazard && !flush;
  assign w_issue  = in_valid && in_ready;
  // A flushed entry will never write back, so release its destination.
  assign w_kill   = flush && r_out_valid && r_out_writes_rd;

  decode_issue_scoreboard u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_set_en   (w_issue && w_cls.writes_rd),
    .i_set_idx  (w_rd),
    .i_clr_en   (wb_valid),
    .i_clr_idx  (wb_reg),
    .i_kill_en  (w_kill),
    .i_kill_idx (r_out_rd),
    .i_q_rs1    (w_rs1),
    .i_q_rs2    (w_rs2),
    .i_q_rd     (w_rd),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2),
    .o_pend_rd  (w_pend_rd),
    .o_busy     (busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid     <= 1'b0;
      r_out_opcode    <= '0;
      r_out_rd        <= '0;
      r_out_op_a      <= '0;
      r_out_op_b      <= '0;
      r_out_imm       <= '0;
      r_out_pc        <= '0;
      r_out_writes_rd <= 1'b0;
      r_out_illegal   <= 1'b0;
    end else if (w_issue) begin
      r_out_valid     <= 1'b1;
      r_out_opcode    <= w_opcode;
      r_out_rd        <= w_rd;
      r_out_op_a      <= ReadData1;
      r_out_op_b      <= ReadData2;
      r_out_imm       <= w_imm;
      r_out_pc        <= in_pc;
      r_out_writes_rd <= w_cls.writes_rd;
      r_out_illegal   <= w_cls.illegal;
    end else if (flush || out_ready) begin
      r_out_valid     <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_opcode    = r_out_opcode;
  assign out_rd        = r_out_rd;
  assign out_op_a      = r_out_op_a;
  assign out_op_b      = r_out_op_b;
  assign out_imm       = r_out_imm;
  assign out_pc        = r_out_pc;
  assign out_writes_rd = r_out_writes_rd;
  assign out_illegal   = r_out_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios plus a randomized run against a
// spec-level model of the issue stage and its register file.
`default_nettype none

module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic [3:0]  RegRead1, RegRead2;
  logic [15:0] ReadData1, ReadData2;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode, out_rd;
  logic [15:0] out_op_a, out_op_b, out_imm, out_pc;
  logic        out_writes_rd, out_illegal;
  logic [15:0] busy;

  logic [15:0] regs [16];
  int tests = 0;
  int fails = 0;

  decode_issue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .RegRead1(RegRead1), .RegRead2(RegRead2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_pc(out_pc), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write on the falling edge.
  assign ReadData1 = regs[RegRead1];
  assign ReadData2 = regs[RegRead2];
  always @(negedge clk) if (wb_valid) regs[wb_reg] <= wb_data;

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic ordy, input logic wbv, input logic [3:0] wbr,
                       input logic [15:0] wbd, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
    wb_valid = wbv; wb_reg = wbr; wb_data = wbd; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 16'h0000) begin fails++; $display("FAIL reset_busy: got %h expected 0000", busy); end
    tests++; if (out_op_a !== 16'h0000 || out_pc !== 16'h0000) begin fails++; $display("FAIL reset_data: got op_a=%h pc=%h expected 0000", out_op_a, out_pc); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_raw();
    drive(1'b1, 16'h1312, 16'h0100, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); #1;
    tests++; if (in_ready !== 1'b1 || RegRead1 !== 4'h1 || RegRead2 !== 4'h2) begin fails++; $display("FAIL raw_first: got rdy=%b rr1=%h rr2=%h expected 1 1 2", in_ready, RegRead1, RegRead2); end
    tick();
    drive(1'b1, 16'h1430, 16'h0102, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); #1;
    tests++; if (out_valid !== 1'b1 || out_rd !== 4'h3 || busy !== 16'h0008) begin fails++; $display("FAIL raw_issue1: got v=%b rd=%h busy=%h expected 1 3 0008", out_valid, out_rd, busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall: got %b expected 0", in_ready); end
    tick(); #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall2: got %b expected 0", in_ready); end
    drive(1'b1, 16'h1430, 16'h0102, 1'b1, 1'b1, 4'h3, 16'hBEEF, 1'b0); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_wb_bypass: got %b expected 1", in_ready); end
    tick(); idle(); #1;
    tests++; if (out_valid !== 1'b1 || out_rd !== 4'h4 || out_op_a !== 16'hBEEF) begin fails++; $display("FAIL raw_issue2: got v=%b rd=%h op_a=%h expected 1 4 beef", out_valid, out_rd, out_op_a); end
    tests++; if (busy !== 16'h0010) begin fails++; $display("FAIL raw_busy: got %h expected 0010", busy); end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'h4, 16'h4444, 1'b0); tick(); idle();
  endtask

  task automatic test_addi();
    drive(1'b1, 16'h851F, 16'h0200, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick(); idle(); #1;
    tests++; if (out_imm !== 16'hFFFF || out_writes_rd !== 1'b1 || out_opcode !== 4'h8) begin fails++; $display("FAIL addi_fields: got imm=%h wr=%b op=%h expected ffff 1 8", out_imm, out_writes_rd, out_opcode); end
    tests++; if (busy !== 16'h0020) begin fails++; $display("FAIL addi_busy: got %h expected 0020", busy); end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'h5, 16'h5555, 1'b0); tick(); idle();
  endtask

  task automatic test_stall();
    drive(1'b1, 16'h1600, 16'h0300, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick();
    drive(1'b1, 16'h1000, 16'h0302, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h0300 || out_rd !== 4'h6) begin fails++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b pc=%h rd=%h expected 0 1 0300 6", i, in_ready, out_valid, out_pc, out_rd); end
      tick();
    end
    out_ready = 1'b1; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b expected 1", in_ready); end
    tick(); idle(); #1;
    tests++; if (out_valid !== 1'b1 || out_pc !== 16'h0302 || busy !== 16'h0041) begin fails++; $display("FAIL stall_next: got v=%b pc=%h busy=%h expected 1 0302 0041", out_valid, out_pc, busy); end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'h6, 16'h6666, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'h0, 16'h0000, 1'b0); tick(); idle();
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h1700, 16'h0400, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick();
    drive(1'b1, 16'h1800, 16'h0402, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1); #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    tick(); idle(); #1;
    tests++; if (out_valid !== 1'b0 || busy !== 16'h0000) begin fails++; $display("FAIL flush_kill: got v=%b busy=%h expected 0 0000", out_valid, busy); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 16'hD234, 16'h0500, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick(); idle(); #1;
    tests++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_writes_rd !== 1'b0 || busy !== 16'h0000) begin fails++; $display("FAIL illegal: got v=%b ill=%b wr=%b busy=%h expected 1 1 0 0000", out_valid, out_illegal, out_writes_rd, busy); end
    drive(1'b1, 16'h1200, 16'h0502, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick();
    drive(1'b1, 16'h1211, 16'h0504, 1'b1, 1'b1, 4'h2, 16'h2222, 1'b0); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL waw_bypass: got %b expected 1", in_ready); end
    tick(); idle(); #1;
    tests++; if (busy !== 16'h0004 || out_pc !== 16'h0504) begin fails++; $display("FAIL set_wins: got busy=%h pc=%h expected 0004 0504", busy, out_pc); end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'h2, 16'h2223, 1'b0); tick(); idle();
  endtask

  task automatic test_random();
    logic [15:0] m_busy, nb;
    logic        m_valid, m_wr, m_ill;
    logic [3:0]  m_op, m_rd;
    logic [15:0] m_a, m_b, m_imm, m_pc;
    logic        v, ordy, wbv, fl, exp_rdy, iss, r1, r2, wr, ill, haz;
    logic [3:0]  op, rd, rs1, rs2, wbr;
    logic [15:0] ins, pc, wbd;
    int          idx;
    do_reset();
    m_busy = '0; m_valid = 1'b0; m_wr = 1'b0; m_ill = 1'b0; m_op = '0; m_rd = '0;
    m_a = '0; m_b = '0; m_imm = '0; m_pc = '0;
    for (int n = 0; n < 400; n++) begin
      op = 4'($urandom_range(15)); rd = 4'($urandom_range(7));
      rs1 = 4'($urandom_range(7)); rs2 = 4'($urandom_range(15));
      ins = {op, rd, rs1, rs2}; pc = 16'($urandom);
      v = ($urandom_range(3) != 0); ordy = ($urandom_range(3) != 0);
      fl = ($urandom_range(15) == 0); wbd = 16'($urandom);
      if (m_busy != 0 && $urandom_range(1) == 1) begin
        do idx = $urandom_range(15); while (!m_busy[idx]);
        wbv = 1'b1; wbr = 4'(idx);
      end else begin
        wbv = ($urandom_range(7) == 0); wbr = 4'($urandom_range(15));
      end
      drive(v, ins, pc, ordy, wbv, wbr, wbd, fl); #1;
      r1  = (op >= 4'h1 && op <= 4'hB);
      r2  = (op >= 4'h1 && op <= 4'h7) || op == 4'hA || op == 4'hB;
      wr  = (op >= 4'h1 && op <= 4'h9);
      ill = (op >= 4'hC && op <= 4'hE);
      haz = (r1 && m_busy[rs1] && !(wbv && wbr == rs1)) ||
            (r2 && m_busy[rs2] && !(wbv && wbr == rs2)) ||
            (wr && m_busy[rd]  && !(wbv && wbr == rd));
      exp_rdy = (!m_valid || ordy) && !haz && !fl;
      tests++; if (in_ready !== exp_rdy || RegRead1 !== rs1 || RegRead2 !== rs2) begin fails++; $display("FAIL rnd_ready[%0d]: got rdy=%b rr=%h/%h expected %b %h/%h", n, in_ready, RegRead1, RegRead2, exp_rdy, rs1, rs2); end
      iss = v && exp_rdy;
      nb = m_busy;
      if (wbv) nb[wbr] = 1'b0;
      if (fl && m_valid && m_wr) nb[m_rd] = 1'b0;
      if (iss && wr) nb[rd] = 1'b1;
      m_busy = nb;
      if (iss) begin
        m_valid = 1'b1; m_op = op; m_rd = rd; m_pc = pc; m_wr = wr; m_ill = ill;
        m_a = (wbv && wbr == rs1) ? wbd : regs[rs1];
        m_b = (wbv && wbr == rs2) ? wbd : regs[rs2];
        m_imm = rs2[3] ? (16'hFFF0 | 16'(rs2)) : 16'(rs2);
      end else if (fl || ordy) begin
        m_valid = 1'b0;
      end
      tick();
      tests++; if (out_valid !== m_valid || busy !== m_busy) begin fails++; $display("FAIL rnd_state[%0d]: got v=%b busy=%h expected %b %h", n, out_valid, busy, m_valid, m_busy); end
      if (m_valid) begin
        tests++;
        if (out_opcode !== m_op || out_rd !== m_rd || out_op_a !== m_a || out_op_b !== m_b ||
            out_imm !== m_imm || out_pc !== m_pc || out_writes_rd !== m_wr || out_illegal !== m_ill) begin
          fails++;
          $display("FAIL rnd_fields[%0d]: got %h %h %h %h %h %h %b %b expected %h %h %h %h %h %h %b %b", n,
                   out_opcode, out_rd, out_op_a, out_op_b, out_imm, out_pc, out_writes_rd, out_illegal,
                   m_op, m_rd, m_a, m_b, m_imm, m_pc, m_wr, m_ill);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(1'b1, 16'h1100, 16'h0600, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick();
    drive(1'b1, 16'h1200, 16'h0602, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0); #1;
    tests++; if (out_valid !== 1'b1 || busy !== 16'h0006) begin fails++; $display("FAIL mid_pre: got v=%b busy=%h expected 1 0006", out_valid, busy); end
    reset_n = 1'b0; #1;
    tests++; if (out_valid !== 1'b0 || busy !== 16'h0000 || out_pc !== 16'h0000) begin fails++; $display("FAIL mid_async: got v=%b busy=%h pc=%h expected 0 0000 0000", out_valid, busy, out_pc); end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    test_reset();
    test_raw();
    test_addi();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage directly upstream of the 16x16 register file. Accepts one 16-bit instruction per cycle over a valid/ready handshake and drives the register file read addresses combinationally. It captures operands into a one-entry ID/EX output register and tracks pending register writes in a 16-bit scoreboard, stalling on RAW/WAW hazards until writeback clears them.

## Interface
- XLEN, 16, data and instruction width
- NREGS, 16, architectural registers; index width log2(NREGS)=4

- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction available
- in_ready  out  1  stage accepts this cycle
- in_instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
- in_pc  in  16  instruction address
- RegRead1, RegRead2  out  4  register file read addresses; combinational from in_instr (rs1, rs2)
- ReadData1, ReadData2  in  16  register file read data (combinational)
- wb_valid  in  1  writeback this cycle (same signal as register file RegWrite)
- wb_reg  in  4  writeback destination (same as WriteReg)
- flush  in  1  kill the output-register entry and block issue this cycle
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  downstream accepts
- out_opcode  out  4; out_rd  out  4
- out_op_a, out_op_b  out  16  captured ReadData1/ReadData2
- out_imm  out  16  sign-extended imm4
- out_pc  out  16
- out_writes_rd  out  1  instruction will write rd
- out_illegal  out  1  reserved opcode
- busy  out  16  scoreboard vector (bit i = write to ri pending)

## Operation
- Opcode classes: 0x0 NOP (no reads, no write); 0x1–0x7 ALU R-type (reads rs1, rs2; writes rd); 0x8 ADDI and 0x9 LOAD (read rs1; write rd); 0xA STORE and 0xB BEQ (read rs1, rs2; no write); 0xC–0xE reserved: issued as NOP with out_illegal=1; 0xF HALT (no reads, no write).
- Hazard: rsX read-used and busy[rsX] and not (wb_valid and wb_reg==rsX); or writes rd and busy[rd] and not cleared this cycle. A same-cycle writeback is visible: the register file writes on negedge before the capturing posedge.
- space = !out_valid or out_ready.
- in_ready = space and !hazard and !flush, where hazard is evaluated on in_instr.
- issue = in_valid and in_ready: load all out_* fields; out_valid<=1; if writes_rd, set busy[rd].
- If out_valid and out_ready and !issue: out_valid<=0.
- Scoreboard per cycle: clear busy[wb_reg] on wb_valid, then apply issue set. Set wins on the same index.
- flush: out_valid<=0; if the killed entry has out_writes_rd, clear busy[out_rd] unless the same cycle sets it. In-flight downstream entries are unaffected.
- wb_valid to a non-busy register: no effect.
- r0 is an ordinary register.

## Timing
- Reset (async assert, sync release): out_valid=0, busy=0, all out_* data=0, in_ready follows combinationally (1 when in_valid is absent or hazard-free).
- Latency: issue at edge N → out_valid and fields valid after edge N.
- Back-to-back issue at 1/cycle with out_ready=1 and no hazards.
- Stall: with out_valid=1 and out_ready=0, all out_* hold stable and in_ready=0.
- RAW stall lasts until the cycle wb_valid clears the register; issue occurs in that same cycle.
- in_ready is combinational from in_instr, busy, wb_*, out_ready, flush. No combinational path from in_valid to in_ready.

## Structure
- decode_pkg: opcode constants, field bit positions, class function (reads_rs1/reads_rs2/writes_rd/illegal).
- Sub-module scoreboard: busy vector, set/clear ports, hazard query for three indices with same-cycle clear bypass.
- decode_issue: handshake, sign-extension, ID/EX register.

## Test plan
- Reset mid-stream with out_valid=1, busy=0x0006: assert reset_n=0 → out_valid=0, busy=0x0000 immediately, without a clock edge.
- ALU 0x1_3_1_2 accepted, then 0x1_4_3_0 with no writeback → second instruction stalls (in_ready=0). Then wb_valid=1, wb_reg=3 → second instruction issues in that cycle; out_op_a equals the written data; busy=0x0010.
- ADDI 0x8_5_1_F → out_imm=0xFFFF, out_writes_rd=1, busy[5] set.
- out_ready=0 for 3 cycles with valid entry → out_* stable, in_ready=0; release → next instruction issues on the same cycle.
- flush with killed entry writing r7 → busy[7]=0 after edge, out_valid=0, and the in_instr presented that cycle is not accepted.
- Opcode 0xD → out_illegal=1, out_writes_rd=0, busy unchanged. A simultaneous wb_valid to r2 and issue writing r2 → busy[2]=1.
